mem_stage_ctrl: RTL and testbench

//   MEM-stage sequencer that consumes the EXE/MEM pipeline register outputs.

---
 rtl/mem_stage_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mem_stage_ctrl: MEM-stage sequencer for data-memory req/ack accesses,       |
// | pipeline stall generation and registered writeback outputs.                 |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module mem_stage_ctrl #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_alu_out,
  input  logic [DATA_W-1:0] mem_reg2_val,
  input  logic [REG_W-1:0]  mem_fwd_reg,
  input  logic [DATA_W-1:0] mem_lb_const,
  input  logic              mem_mem_read,
  input  logic              mem_mem_write,
  input  logic [1:0]        mem_memtoreg,
  input  logic              mem_regwrite,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_dest,
  output logic              wb_regwrite,
  output logic              err_timeout,
  output logic              err_rw
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_cnt;
  logic [REG_W-1:0]    r_dest;
  logic [1:0]          r_memtoreg;
  logic                r_regwrite;
  logic [DATA_W-1:0]   r_lb_const;
  logic                w_op;
  logic                w_expire;

  function automatic logic [DATA_W-1:0] wb_select(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] rdata,
    input logic [DATA_W-1:0] lbc
  );
    case (sel)
      2'b00:   wb_select = alu;
      2'b01:   wb_select = rdata;
      2'b10:   wb_select = lbc;
      default: wb_select = {{(DATA_W-8){1'b0}}, rdata[7:0]};
    endcase
  endfunction

  assign w_op     = mem_mem_read | mem_mem_write;
  assign w_expire = (r_cnt == c_CNT_LAST);
  assign stall    = ((r_state == ST_IDLE) && w_op) || (r_state == ST_WAIT);

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_op) w_state_nxt = ST_WAIT;
      ST_WAIT: if (dmem_ack || w_expire) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      wb_data     <= '0;
      wb_dest     <= '0;
      wb_regwrite <= 1'b0;
      err_timeout <= 1'b0;
      err_rw      <= 1'b0;
      r_cnt       <= '0;
      r_dest      <= '0;
      r_memtoreg  <= '0;
      r_regwrite  <= 1'b0;
      r_lb_const  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_op) begin
            // A simultaneous read and write is issued as a load.
            dmem_req    <= 1'b1;
            dmem_we     <= mem_mem_write & ~mem_mem_read;
            dmem_addr   <= mem_alu_out;
            dmem_wdata  <= mem_reg2_val;
            r_dest      <= mem_fwd_reg;
            r_memtoreg  <= mem_memtoreg;
            r_regwrite  <= mem_regwrite;
            r_lb_const  <= mem_lb_const;
            r_cnt       <= '0;
            wb_regwrite <= 1'b0;
            if (mem_mem_read && mem_mem_write) err_rw <= 1'b1;
          end else begin
            wb_data     <= wb_select(mem_memtoreg, mem_alu_out, dmem_rdata, mem_lb_const);
            wb_dest     <= mem_fwd_reg;
            wb_regwrite <= mem_regwrite;
          end
        end
        ST_WAIT: begin
          if (dmem_ack) begin
            // The latched address doubles as the ALU result of the held instruction.
            wb_data     <= wb_select(r_memtoreg, dmem_addr, dmem_rdata, r_lb_const);
            wb_dest     <= r_dest;
            wb_regwrite <= r_regwrite;
            dmem_req    <= 1'b0;
          end else if (w_expire) begin
            dmem_req    <= 1'b0;
            err_timeout <= 1'b1;
            wb_regwrite <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_RESP: wb_regwrite <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mem_stage_ctrl: directed self-checking bench for mem_stage_ctrl.         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_mem_stage_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] mem_alu_out, mem_reg2_val, mem_lb_const, dmem_rdata;
  logic [2:0]  mem_fwd_reg;
  logic        mem_mem_read, mem_mem_write, mem_regwrite, dmem_ack;
  logic [1:0]  mem_memtoreg;
  logic        dmem_req, dmem_we, stall, wb_regwrite, err_timeout, err_rw;
  logic [15:0] dmem_addr, dmem_wdata, wb_data;
  logic [2:0]  wb_dest;

  int tests_run = 0;
  int tests_failed = 0;
  int req_count = 0;
  logic req_q = 1'b0;

  always #5 clock = ~clock;

  mem_stage_ctrl #(.DATA_W(16), .REG_W(3), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .mem_alu_out(mem_alu_out), .mem_reg2_val(mem_reg2_val), .mem_fwd_reg(mem_fwd_reg),
    .mem_lb_const(mem_lb_const), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
    .wb_data(wb_data), .wb_dest(wb_dest), .wb_regwrite(wb_regwrite),
    .err_timeout(err_timeout), .err_rw(err_rw)
  );

  // Count request rising edges to catch duplicate issues.
  always @(negedge clock) begin
    if (dmem_req && !req_q) req_count++;
    req_q = dmem_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [15:0] alu,
                        input logic [15:0] r2, input logic [2:0] fwd, input logic [1:0] m2r,
                        input logic rw, input logic [15:0] lbc);
    mem_mem_read  = rd;
    mem_mem_write = wr;
    mem_alu_out   = alu;
    mem_reg2_val  = r2;
    mem_fwd_reg   = fwd;
    mem_memtoreg  = m2r;
    mem_regwrite  = rw;
    mem_lb_const  = lbc;
  endtask

  task automatic nop();
    set_op(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 2'b00, 1'b0, 16'h0000);
  endtask

  initial begin
    reset = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 16'h0000;
    nop();
    step();
    step();
    check("rst_req", dmem_req, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_rw", wb_regwrite, 0);
    check("rst_errs", {err_timeout, err_rw}, 0);
    reset = 1'b0;

    // ALU pass-through
    set_op(1'b0, 1'b0, 16'h1234, 16'h0000, 3'd3, 2'b00, 1'b1, 16'h0000);
    #1 check("alu_stall", stall, 0);
    step();
    check("alu_data", wb_data, 16'h1234);
    check("alu_dest", wb_dest, 3);
    check("alu_rw", wb_regwrite, 1);

    // Load with ack three cycles after request
    set_op(1'b1, 1'b0, 16'h0040, 16'h0000, 3'd5, 2'b01, 1'b1, 16'h0000);
    #1 check("ld_stall_idle", stall, 1);
    step();
    check("ld_req", {dmem_req, dmem_we, stall}, 3'b101);
    check("ld_addr", dmem_addr, 16'h0040);
    check("ld_rw_low", wb_regwrite, 0);
    step();
    step();
    check("ld_hold", {dmem_req, stall, dmem_addr}, {2'b11, 16'h0040});
    dmem_ack = 1'b1;
    dmem_rdata = 16'hBEEF;
    step();
    dmem_ack = 1'b0;
    check("ld_resp", {dmem_req, stall}, 2'b00);
    check("ld_data", wb_data, 16'hBEEF);
    check("ld_dest_rw", {wb_dest, wb_regwrite}, {3'd5, 1'b1});
    nop();
    step();
    check("ld_rw_clear", wb_regwrite, 0);

    // Store
    set_op(1'b0, 1'b1, 16'h0010, 16'hA5A5, 3'd2, 2'b00, 1'b0, 16'h0000);
    step();
    check("st_req", {dmem_req, dmem_we}, 2'b11);
    check("st_bus", {dmem_addr, dmem_wdata}, {16'h0010, 16'hA5A5});
    step();
    check("st_hold", {dmem_req, dmem_we, dmem_wdata}, {2'b11, 16'hA5A5});
    dmem_ack = 1'b1;
    dmem_rdata = 16'h0000;
    step();
    dmem_ack = 1'b0;
    check("st_done", {dmem_req, wb_regwrite}, 2'b00);
    check("st_data", wb_data, 16'h0010);
    nop();
    step();
    step();
    check("req_count_ld_st", req_count, 2);

    // Byte-load and load-constant selections
    set_op(1'b1, 1'b0, 16'h0020, 16'h0000, 3'd1, 2'b11, 1'b1, 16'h0000);
    step();
    dmem_ack = 1'b1;
    dmem_rdata = 16'h12F7;
    step();
    dmem_ack = 1'b0;
    check("lbu_data", wb_data, 16'h00F7);
    nop();
    step();
    set_op(1'b1, 1'b0, 16'h0030, 16'h0000, 3'd4, 2'b10, 1'b1, 16'h0055);
    step();
    mem_lb_const = 16'hFFFF;
    dmem_ack = 1'b1;
    dmem_rdata = 16'h1111;
    step();
    dmem_ack = 1'b0;
    check("lbc_data", wb_data, 16'h0055);
    check("lbc_dest", wb_dest, 4);
    nop();
    step();

    // Ack on the last permitted WAIT cycle is a success
    set_op(1'b1, 1'b0, 16'h0044, 16'h0000, 3'd6, 2'b01, 1'b1, 16'h0000);
    step();
    for (int i = 0; i < 14; i++) step();
    check("edge_req", dmem_req, 1);
    dmem_ack = 1'b1;
    dmem_rdata = 16'hCAFE;
    step();
    dmem_ack = 1'b0;
    check("edge_data", wb_data, 16'hCAFE);
    check("edge_ok", {wb_regwrite, err_timeout}, 2'b10);
    nop();
    step();

    // Timeout after 15 WAIT cycles
    set_op(1'b1, 1'b0, 16'h0050, 16'h0000, 3'd7, 2'b01, 1'b1, 16'h0000);
    step();
    for (int i = 0; i < 14; i++) step();
    check("to_req_held", {dmem_req, stall}, 2'b11);
    step();
    check("to_req_drop", {dmem_req, stall}, 2'b00);
    check("to_err", {err_timeout, wb_regwrite}, 2'b10);
    nop();
    dmem_ack = 1'b1;
    dmem_rdata = 16'h7777;
    step();
    dmem_ack = 1'b0;
    check("to_late_ack", {dmem_req, wb_regwrite, err_timeout}, 3'b001);

    // Reset in the middle of WAIT
    set_op(1'b1, 1'b0, 16'h0070, 16'h0000, 3'd3, 2'b01, 1'b1, 16'h0000);
    step();
    check("rw_req_pre", dmem_req, 1);
    reset = 1'b1;
    nop();
    step();
    reset = 1'b0;
    check("rw_rst_outs", {dmem_req, dmem_we, wb_regwrite, err_timeout, err_rw, stall}, 0);
    check("rw_rst_data", {wb_data, dmem_addr}, 0);
    dmem_ack = 1'b1;
    dmem_rdata = 16'h9999;
    step();
    dmem_ack = 1'b0;
    check("rw_late_ack", {dmem_req, wb_regwrite}, 2'b00);
    check("rw_late_data", wb_data, 16'h0000);

    // Read and write together: issued as a load, flagged
    set_op(1'b1, 1'b1, 16'h0060, 16'h1234, 3'd2, 2'b01, 1'b1, 16'h0000);
    #1 check("both_stall", stall, 1);
    step();
    check("both_req", {dmem_req, dmem_we, err_rw}, 3'b101);
    dmem_ack = 1'b1;
    dmem_rdata = 16'h4321;
    step();
    dmem_ack = 1'b0;
    check("both_data", wb_data, 16'h4321);
    nop();
    step();
    check("both_sticky", err_rw, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
